// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALU opcodes, ALUOp
// encodings, funct3 values and the issue FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ALUOP_LDST  = 2'b00,
    ALUOP_BR    = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct decode to a 4-bit ALU operation plus an
// illegal flag for encodings the ALU does not support.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] operation,
  output logic       illegal
);

  always_comb begin
    operation = ALU_ADD;
    illegal   = 1'b0;
    case (aluop_e'(aluop))
      ALUOP_LDST: operation = ALU_ADD;
      ALUOP_BR:   operation = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct3)
          F3_ADDSUB: operation = funct7_5 ? ALU_SUB : ALU_ADD;
          F3_AND:    operation = ALU_AND;
          F3_OR:     operation = ALU_OR;
          default:   illegal   = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one request, drives the ALU for one cycle and
// holds the result until taken. Optional zero flag: ALU_ISSUE_ZERO_FLAG_EN.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_aluop,
  input  logic [2:0]  req_funct3,
  input  logic        req_funct7_5,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  alu_operation,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_illegal
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  ,
  output logic        rsp_zero
`endif
);

  state_e     state, next_state;
  logic [3:0] dec_op;
  logic       dec_illegal;
  logic       accept;

  alu_op_decode u_decode (
    .aluop     (req_aluop),
    .funct3    (req_funct3),
    .funct7_5  (req_funct7_5),
    .operation (dec_op),
    .illegal   (dec_illegal)
  );

  assign accept = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = dec_illegal ? ST_RESP : ST_EXEC;
      end
      ST_EXEC: next_state = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // ALU drive only changes on a legal accept; illegal requests leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_operation <= ALU_AND;
      alu_in1       <= '0;
      alu_in2       <= '0;
    end else if (accept && !dec_illegal) begin
      alu_operation <= dec_op;
      alu_in1       <= req_a;
      alu_in2       <= req_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result  <= '0;
      rsp_illegal <= 1'b0;
    end else if (accept && dec_illegal) begin
      rsp_result  <= '0;
      rsp_illegal <= 1'b1;
    end else if (state == ST_EXEC) begin
      rsp_result  <= alu_result;
      rsp_illegal <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      rsp_zero <= 1'b0;
    else if (accept && dec_illegal)  rsp_zero <= 1'b0;
    else if (state == ST_EXEC)       rsp_zero <= (alu_result == '0);
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU on the drive
// port. Builds with or without ALU_ISSUE_ZERO_FLAG_EN.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_aluop;
  logic [2:0]  req_funct3;
  logic        req_funct7_5;
  logic [31:0] req_a, req_b;
  logic [3:0]  alu_operation;
  logic [31:0] alu_in1, alu_in2;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_illegal;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic        rsp_zero;
`endif

  typedef struct {
    logic [31:0] result;
    logic        illegal;
    logic        zero;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_aluop     (req_aluop),
    .req_funct3    (req_funct3),
    .req_funct7_5  (req_funct7_5),
    .req_a         (req_a),
    .req_b         (req_b),
    .alu_operation (alu_operation),
    .alu_in1       (alu_in1),
    .alu_in2       (alu_in2),
    .alu_result    (alu_result),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_illegal   (rsp_illegal)
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    ,
    .rsp_zero      (rsp_zero)
`endif
  );

  // Behavioural ALU standing in for the real datapath.
  always_comb begin
    alu_result = '0;
    case (alu_operation)
      4'b0000: alu_result = alu_in1 & alu_in2;
      4'b0001: alu_result = alu_in1 | alu_in2;
      4'b0010: alu_result = alu_in1 + alu_in2;
      4'b0110: alu_result = alu_in1 - alu_in2;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".alu_operation"}, {28'd0, alu_operation}, 32'd0);
    check({tag, ".alu_in1"}, alu_in1, 32'd0);
    check({tag, ".alu_in2"}, alu_in2, 32'd0);
    check({tag, ".rsp_result"}, rsp_result, 32'd0);
    check({tag, ".rsp_illegal"}, {31'd0, rsp_illegal}, 32'd0);
    check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    check({tag, ".rsp_zero"}, {31'd0, rsp_zero}, 32'd0);
`endif
  endtask

  // One request end to end; exp_op is the required ALU opcode for legal ones,
  // stall_cycles holds rsp_ready low while junk requests are offered.
  task automatic run_req(input string tag, input logic [1:0] aluop, input logic [2:0] f3,
                         input logic f75, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] exp_op, input logic [31:0] exp_res,
                         input logic exp_ill, input int unsigned stall_cycles);
    logic [3:0]  prev_op;
    logic [31:0] prev_in1, prev_in2, held;
    int unsigned lat;
    exp_t        e;
    @(negedge clk);
    check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    prev_op  = alu_operation;
    prev_in1 = alu_in1;
    prev_in2 = alu_in2;
    req_valid = 1'b1; req_aluop = aluop; req_funct3 = f3; req_funct7_5 = f75;
    req_a = a; req_b = b;
    rsp_ready = (stall_cycles == 0);
    exp_q.push_back('{result: exp_res, illegal: exp_ill, zero: (!exp_ill && exp_res == 0)});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_aluop = 2'($urandom); req_funct3 = 3'($urandom); req_funct7_5 = 1'($urandom);
    req_a = $urandom; req_b = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, exp_ill ? 32'd1 : 32'd2);
    if (exp_ill) begin
      check({tag, ".drive_op_held"}, {28'd0, alu_operation}, {28'd0, prev_op});
      check({tag, ".drive_in1_held"}, alu_in1, prev_in1);
      check({tag, ".drive_in2_held"}, alu_in2, prev_in2);
    end else begin
      check({tag, ".alu_operation"}, {28'd0, alu_operation}, {28'd0, exp_op});
      check({tag, ".alu_in1"}, alu_in1, a);
      check({tag, ".alu_in2"}, alu_in2, b);
    end
    if (exp_q.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".rsp_result"}, rsp_result, e.result);
      check({tag, ".rsp_illegal"}, {31'd0, rsp_illegal}, {31'd0, e.illegal});
`ifdef ALU_ISSUE_ZERO_FLAG_EN
      check({tag, ".rsp_zero"}, {31'd0, rsp_zero}, {31'd0, e.zero});
`endif
    end
    held = rsp_result;
    for (int unsigned i = 0; i < stall_cycles; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      check({tag, ".stall_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, ".stall_result"}, rsp_result, held);
      check({tag, ".stall_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, ".done_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, ".done_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_aluop = '0; req_funct3 = '0; req_funct7_5 = 1'b0;
    req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("reset.req_ready", {31'd0, req_ready}, 32'd1);

    run_req("rtype_add", 2'b10, 3'b000, 1'b0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 0);
    run_req("branch_sub", 2'b01, 3'b101, 1'b1, 32'd3, 32'd5, 4'b0110, 32'hFFFF_FFFE, 1'b0, 0);
    run_req("branch_eq", 2'b01, 3'b000, 1'b0, 32'd9, 32'd9, 4'b0110, 32'd0, 1'b0, 0);
    run_req("ldst_add", 2'b00, 3'b111, 1'b1, 32'h0000_1000, 32'h0000_0024, 4'b0010, 32'h0000_1024, 1'b0, 0);
    run_req("rtype_and", 2'b10, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 32'hF000_F000, 1'b0, 0);
    run_req("rtype_or", 2'b10, 3'b110, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0001, 32'hFFF0_FFF0, 1'b0, 0);
    run_req("illegal_rsvd", 2'b11, 3'b000, 1'b0, 32'd1, 32'd2, 4'b0000, 32'd0, 1'b1, 0);
    run_req("illegal_f3", 2'b10, 3'b001, 1'b0, 32'd4, 32'd8, 4'b0000, 32'd0, 1'b1, 0);
    run_req("stall_sub", 2'b10, 3'b000, 1'b1, 32'h10, 32'h3, 4'b0110, 32'hD, 1'b0, 5);
    run_req("stall_illegal", 2'b10, 3'b010, 1'b0, 32'h10, 32'h3, 4'b0000, 32'd0, 1'b1, 3);

    // Abort a request while it is in EXEC.
    @(negedge clk);
    req_valid = 1'b1; req_aluop = 2'b00; req_funct3 = '0; req_funct7_5 = 1'b0;
    req_a = 32'hDEAD_0000; req_b = 32'h0000_BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort.in_exec_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort.req_ready", {31'd0, req_ready}, 32'd1);
    check("abort.rsp_valid", {31'd0, rsp_valid}, 32'd0);

    run_req("post_reset_add", 2'b10, 3'b000, 1'b0, 32'd100, 32'd23, 4'b0010, 32'd123, 1'b0, 0);

    check("scoreboard.left", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
